// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode constants, immediate-format codes,
// the op-class enum and the decoded packet handed to rename/dispatch.
package decode_pkg;

  localparam int XLEN  = 32;
  localparam int IMM_W = 25;
  localparam int SRC_W = 3;

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate format codes understood by the extend unit.
  localparam logic [SRC_W-1:0] IMM_I = 3'b000;
  localparam logic [SRC_W-1:0] IMM_S = 3'b001;
  localparam logic [SRC_W-1:0] IMM_B = 3'b010;
  localparam logic [SRC_W-1:0] IMM_U = 3'b011;
  localparam logic [SRC_W-1:0] IMM_J = 3'b100;

  typedef enum logic [3:0] {
    CLS_ALU_R   = 4'd0,
    CLS_ALU_I   = 4'd1,
    CLS_LOAD    = 4'd2,
    CLS_STORE   = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_JAL     = 4'd5,
    CLS_JALR    = 4'd6,
    CLS_LUI     = 4'd7,
    CLS_AUIPC   = 4'd8,
    CLS_ILLEGAL = 4'd9
  } op_class_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [4:0]       rd;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [2:0]       funct3;
    logic             funct7b5;
    logic [SRC_W-1:0] imm_src;
    logic [XLEN-1:0]  imm_ext;
    op_class_e        op_class;
    logic             uses_rs2;
    logic             writes_rd;
  } decoded_pkt_t;

endpackage

// File: rtl/decode_ctrl.sv
// Combinational opcode classifier.
//   opcode    : instr[6:0]
//   rd        : instr[11:7], needed to suppress writes to x0
//   op_class  : instruction class
//   imm_src   : immediate format code for the extend unit
//   imm_zero  : immediate must be forced to zero (R-type, illegal)
//   uses_rs2  : rs2 is a real source operand
//   writes_rd : instruction writes a non-zero rd
module decode_ctrl
  import decode_pkg::*;
(
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  output op_class_e        op_class,
  output logic [SRC_W-1:0] imm_src,
  output logic             imm_zero,
  output logic             uses_rs2,
  output logic             writes_rd
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a value
    // unassigned, which would otherwise infer a latch.
    op_class = CLS_ILLEGAL;
    imm_src  = IMM_I;
    imm_zero = 1'b0;
    unique case (opcode)
      OP_LOAD:   op_class = CLS_LOAD;
      OP_OP_IMM: op_class = CLS_ALU_I;
      OP_JALR:   op_class = CLS_JALR;
      OP_STORE:  begin op_class = CLS_STORE;  imm_src = IMM_S; end
      OP_BRANCH: begin op_class = CLS_BRANCH; imm_src = IMM_B; end
      OP_LUI:    begin op_class = CLS_LUI;    imm_src = IMM_U; end
      OP_AUIPC:  begin op_class = CLS_AUIPC;  imm_src = IMM_U; end
      OP_JAL:    begin op_class = CLS_JAL;    imm_src = IMM_J; end
      OP_OP:     begin op_class = CLS_ALU_R;  imm_zero = 1'b1; end
      default:   imm_zero = 1'b1;
    endcase
    // Every legal opcode ends in 2'b11, so the full-width match above already
    // sends anything else to ILLEGAL.
    uses_rs2  = (op_class == CLS_ALU_R) || (op_class == CLS_STORE) ||
                (op_class == CLS_BRANCH);
    writes_rd = (op_class != CLS_STORE) && (op_class != CLS_BRANCH) &&
                (op_class != CLS_ILLEGAL) && (rd != 5'd0);
  end

endmodule

// File: rtl/extend.sv
// Immediate extend unit.
//   instr   : instruction bits [31:7]
//   imm_src : format code (I/S/B/U/J)
//   imm_ext : 32-bit sign/zero-extended immediate
module extend (
  input  logic [24:0] instr,
  input  logic [2:0]  imm_src,
  output logic [31:0] imm_ext
);

  // Bit k of the full instruction sits at instr[k-7] here.
  always_comb begin
    case (imm_src)
      3'b000:  imm_ext = {{20{instr[24]}}, instr[24:13]};
      3'b001:  imm_ext = {{20{instr[24]}}, instr[24:18], instr[4:0]};
      3'b010:  imm_ext = {{20{instr[24]}}, instr[0], instr[23:18], instr[4:1], 1'b0};
      3'b011:  imm_ext = {instr[24:5], 12'b0};
      3'b100:  imm_ext = {{12{instr[24]}}, instr[12:5], instr[13], instr[23:14], 1'b0};
      default: imm_ext = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one-entry registered slice between fetch and
// rename/dispatch with valid/ready handshake, stall and flush.
//   clk, reset_n           : clock, async active-low reset
//   flush                  : kill held and incoming instruction
//   in_valid/in_ready      : fetch handshake; in_instr, in_pc payload
//   out_valid/out_ready    : downstream handshake
//   out_*                  : registered decoded packet fields
module decode_stage
  import decode_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic             out_funct7b5,
  output logic [SRC_W-1:0] out_immSrc,
  output logic [XLEN-1:0]  out_immExt,
  output logic [3:0]       out_class,
  output logic             out_uses_rs2,
  output logic             out_writes_rd
);

  op_class_e        dec_class;
  logic [SRC_W-1:0] dec_imm_src;
  logic             dec_imm_zero;
  logic             dec_uses_rs2;
  logic             dec_writes_rd;
  logic [XLEN-1:0]  ext_imm;

  logic             accept;
  logic             transfer;
  logic             valid_q, valid_d;
  decoded_pkt_t     pkt_q, pkt_d, pkt_new;

  decode_ctrl u_ctrl (
    .opcode    (in_instr[6:0]),
    .rd        (in_instr[11:7]),
    .op_class  (dec_class),
    .imm_src   (dec_imm_src),
    .imm_zero  (dec_imm_zero),
    .uses_rs2  (dec_uses_rs2),
    .writes_rd (dec_writes_rd)
  );

  extend u_extend (
    .instr   (in_instr[31:7]),
    .imm_src (dec_imm_src),
    .imm_ext (ext_imm)
  );

  // Ready whenever the register is empty or draining this cycle, so a
  // continuous stream flows without bubbles.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign transfer = valid_q && out_ready;

  always_comb begin
    pkt_new           = '0;
    pkt_new.pc        = in_pc;
    pkt_new.rd        = in_instr[11:7];
    pkt_new.rs1       = in_instr[19:15];
    pkt_new.rs2       = in_instr[24:20];
    pkt_new.funct3    = in_instr[14:12];
    pkt_new.funct7b5  = in_instr[30];
    pkt_new.imm_src   = dec_imm_src;
    pkt_new.imm_ext   = dec_imm_zero ? '0 : ext_imm;
    pkt_new.op_class  = dec_class;
    pkt_new.uses_rs2  = dec_uses_rs2;
    pkt_new.writes_rd = dec_writes_rd;
  end

  // Flush wins over accept and transfer. The payload only changes on an
  // accept, which keeps it bit-stable through a stall.
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
      pkt_d   = pkt_new;
    end else if (transfer) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      // NOTE: the payload register is reset too (not just valid) because
      // the data outputs must read zero out of reset.
      pkt_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign out_valid     = valid_q;
  assign out_pc        = pkt_q.pc;
  assign out_rd        = pkt_q.rd;
  assign out_rs1       = pkt_q.rs1;
  assign out_rs2       = pkt_q.rs2;
  assign out_funct3    = pkt_q.funct3;
  assign out_funct7b5  = pkt_q.funct7b5;
  assign out_immSrc    = pkt_q.imm_src;
  assign out_immExt    = pkt_q.imm_ext;
  assign out_class     = pkt_q.op_class;
  assign out_uses_rs2  = pkt_q.uses_rs2;
  assign out_writes_rd = pkt_q.writes_rd;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed vectors with literal
// expectations plus a queue-based reference model checked every cycle.
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [2:0]  out_immSrc;
  logic [31:0] out_immExt;
  logic [3:0]  out_class;
  logic        out_uses_rs2, out_writes_rd;

  decode_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .in_pc         (in_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_rd        (out_rd),
    .out_rs1       (out_rs1),
    .out_rs2       (out_rs2),
    .out_funct3    (out_funct3),
    .out_funct7b5  (out_funct7b5),
    .out_immSrc    (out_immSrc),
    .out_immExt    (out_immExt),
    .out_class     (out_class),
    .out_uses_rs2  (out_uses_rs2),
    .out_writes_rd (out_writes_rd)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic        f7b5;
    logic [2:0]  src;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic        u2, wr;
  } exp_t;

  // Reference decode straight from the ISA field definitions, using shifts
  // and masks on the whole instruction word.
  function automatic exp_t model(input logic [31:0] instr, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] sgn;
    logic [31:0] i_imm;
    sgn   = instr[31] ? 32'hFFFF_FFFF : 32'h0;
    i_imm = $unsigned($signed(instr) >>> 20);
    e.pc   = pc;
    e.rd   = instr[11:7];
    e.rs1  = instr[19:15];
    e.rs2  = instr[24:20];
    e.f3   = instr[14:12];
    e.f7b5 = instr[30];
    e.src  = 3'd0;
    e.imm  = 32'h0;
    case (instr[6:0])
      7'h03: begin e.cls = CLS_LOAD;   e.imm = i_imm; end
      7'h13: begin e.cls = CLS_ALU_I;  e.imm = i_imm; end
      7'h67: begin e.cls = CLS_JALR;   e.imm = i_imm; end
      7'h23: begin e.cls = CLS_STORE;  e.src = 3'd1;
                   e.imm = (i_imm & ~32'h1F) | 32'(instr[11:7]); end
      7'h63: begin e.cls = CLS_BRANCH; e.src = 3'd2;
                   e.imm = (sgn << 12) | (32'(instr[7]) << 11) |
                           (32'(instr[30:25]) << 5) | (32'(instr[11:8]) << 1); end
      7'h37: begin e.cls = CLS_LUI;    e.src = 3'd3; e.imm = instr & 32'hFFFF_F000; end
      7'h17: begin e.cls = CLS_AUIPC;  e.src = 3'd3; e.imm = instr & 32'hFFFF_F000; end
      7'h6F: begin e.cls = CLS_JAL;    e.src = 3'd4;
                   e.imm = (sgn << 20) | (32'(instr[19:12]) << 12) |
                           (32'(instr[20]) << 11) | (32'(instr[30:21]) << 1); end
      7'h33: e.cls = CLS_ALU_R;
      default: e.cls = CLS_ILLEGAL;
    endcase
    e.u2 = (e.cls == CLS_ALU_R) || (e.cls == CLS_STORE) || (e.cls == CLS_BRANCH);
    e.wr = !((e.cls == CLS_STORE) || (e.cls == CLS_BRANCH) || (e.cls == CLS_ILLEGAL)) &&
           (e.rd != 5'd0);
    return e;
  endfunction

  // Model state: the packet the stage must be holding (at most one).
  exp_t q[$];

  always @(posedge clk) begin
    bit give, take;
    if (!reset_n) begin
      q.delete();
    end else begin
      give = (q.size() != 0) && out_ready;
      take = in_valid && ((q.size() == 0) || out_ready);
      if (flush) begin
        q.delete();
      end else begin
        if (give) void'(q.pop_front());
        if (take) q.push_back(model(in_instr, in_pc));
      end
    end
  end

  logic [95:0] snap;
  bit          stall_pend = 0;

  function automatic logic [95:0] outs();
    return {3'b0, out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_funct7b5,
            out_immSrc, out_immExt, out_class, out_uses_rs2, out_writes_rd, out_valid};
  endfunction

  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_valid", out_valid, 0);
      check("rst_ready", in_ready, 1);
      stall_pend = 0;
    end else begin
      check("in_ready", in_ready, (q.size() == 0) || out_ready);
      check("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        check("pc",       out_pc,        q[0].pc);
        check("rd",       out_rd,        q[0].rd);
        check("rs1",      out_rs1,       q[0].rs1);
        check("rs2",      out_rs2,       q[0].rs2);
        check("funct3",   out_funct3,    q[0].f3);
        check("funct7b5", out_funct7b5,  q[0].f7b5);
        check("immSrc",   out_immSrc,    q[0].src);
        check("immExt",   out_immExt,    q[0].imm);
        check("class",    out_class,     q[0].cls);
        check("uses_rs2", out_uses_rs2,  q[0].u2);
        check("writes_rd",out_writes_rd, q[0].wr);
      end
      if (stall_pend) check("stall_stable", outs(), snap);
      stall_pend = (q.size() != 0) && !out_ready && !flush;
    end
    snap = outs();
  end

  // Present one instruction and hold it until the stage takes it.
  task automatic issue(input logic [31:0] instr, input logic [31:0] pc);
    bit ok;
    int n;
    ok = 0;
    n  = 0;
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    do begin
      @(negedge clk);
      ok = in_ready;
      n++;
      @(posedge clk);
      #1;
    end while (!ok && n < 50);
    if (!ok) check("issue_timeout", ok, 1);
    in_valid = 1'b0;
  endtask

  // Literal expectations for the packet that must be visible one cycle
  // after the accepting edge.
  task automatic expect_pkt(input string tag, input logic [3:0] cls, input logic [2:0] src,
                            input logic [31:0] imm, input logic [4:0] rd,
                            input logic u2, input logic wr);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_class"}, out_class, cls);
    check({tag, "_src"},   out_immSrc, src);
    check({tag, "_imm"},   out_immExt, imm);
    check({tag, "_rd"},    out_rd, rd);
    check({tag, "_u2"},    out_uses_rs2, u2);
    check({tag, "_wr"},    out_writes_rd, wr);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] stream [4];
    stream = '{32'h010000EF, 32'h00008067, 32'h00001397, 32'hFF812203};

    #2;
    check("reset_outputs", outs(), 96'h0);
    #11 reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", in_ready, 1);

    out_ready = 1'b1;
    issue(32'hFFF00093, 32'h100);
    expect_pkt("addi", CLS_ALU_I, 3'd0, 32'hFFFF_FFFF, 5'd1, 1'b0, 1'b1);
    issue(32'h0020A423, 32'h104);
    @(negedge clk);
    check("sw_rs1", out_rs1, 5'd1);
    check("sw_rs2", out_rs2, 5'd2);
    @(posedge clk); #1;
    issue(32'h0020A423, 32'h108);
    expect_pkt("sw", CLS_STORE, 3'd1, 32'h8, 5'd8, 1'b1, 1'b0);
    issue(32'hFE000EE3, 32'h10C);
    expect_pkt("beq", CLS_BRANCH, 3'd2, 32'hFFFF_FFFC, 5'd29, 1'b1, 1'b0);
    issue(32'h123452B7, 32'h110);
    expect_pkt("lui", CLS_LUI, 3'd3, 32'h1234_5000, 5'd5, 1'b0, 1'b1);
    issue(32'h002081B3, 32'h114);
    expect_pkt("add", CLS_ALU_R, 3'd0, 32'h0, 5'd3, 1'b1, 1'b1);
    issue(32'h0000007F, 32'h118);
    expect_pkt("ill7f", CLS_ILLEGAL, 3'd0, 32'h0, 5'd0, 1'b0, 1'b0);
    issue(32'h00000000, 32'h11C);
    expect_pkt("ill00", CLS_ILLEGAL, 3'd0, 32'h0, 5'd0, 1'b0, 1'b0);
    issue(32'hFFF00091, 32'h120);
    expect_pkt("ill_lo", CLS_ILLEGAL, 3'd0, 32'h0, 5'd1, 1'b0, 1'b0);

    // Back-to-back stream with a three-cycle downstream stall.
    fork
      begin
        for (int i = 0; i < 4; i++) issue(stream[i], 32'h200 + 32'(i * 4));
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("stream_drained", q.size(), 0);
    check("stream_idle", out_valid, 0);

    // Flush while stalled with a new instruction offered.
    out_ready = 1'b0;
    issue(32'h00500313, 32'h300);
    in_valid = 1'b1; in_instr = 32'h00600393; in_pc = 32'h304; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_stalled", out_valid, 0);
    // Flush while idle and ready: the incoming instruction is dropped.
    in_valid = 1'b1; in_instr = 32'h00700413; in_pc = 32'h308; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", out_valid, 0);
    @(posedge clk); #1;
    check("flush_no_ghost", out_valid, 0);

    // Asynchronous reset in the middle of a stall.
    issue(32'h00800493, 32'h400);
    check("prereset_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_pc", out_pc, 32'h0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_reset_idle", out_valid, 0);
    issue(32'h00900513, 32'h500);
    expect_pkt("post_rst", CLS_ALU_I, 3'd0, 32'h9, 5'd10, 1'b0, 1'b1);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
